tank_ctrl_multi: RTL and testbench
==================================

// Module: tank_ctrl_multi
// PURPOSE
//  Per-player tank controller, next generation: parametrised field, speeds, bullet pool and
//  multi-key input. Per frame it moves the tank from a USB keycode report and fires
//  edge-triggered, cooldown-limited shots into a pool of NUM_BULLETS independent slots.
//  It also produces per-pixel tank and bullet hit flags for the colour mapper.
//  Sits between the keycode decoder and the VGA colour mapper / collision logic.
// PARAMETERS
//  NUM_BULLETS   4      bullet slots in pool (1..8)
//  NUM_KEYS      2      simultaneous keycodes in report
//  X_MIN/X_MAX   0/639  inclusive horizontal field bounds (pixels)
//  Y_MIN/Y_MAX   0/479  inclusive vertical field bounds
//  TANK_W/TANK_H 32/32  tank sprite size
//  BUL_W/BUL_H   8/8    bullet sprite size
//  TANK_STEP     1      tank pixels per frame
//  BUL_STEP      5      bullet pixels per frame
//  COOLDOWN      15     frames between shots (0 = none)
// PORTS
//  Clk            in   1             50 MHz system clock
//  Reset_n        in   1             synchronous, active-low reset
//  frame_clk      in   1             ~60 Hz frame strobe (VGA vsync domain, already synced)
//  X_Start,Y_Start in  10            tank spawn position, sampled during reset
//  keycodes       in   8*NUM_KEYS    key slot k = [8k+7:8k]; 0x00 = none
//  DrawX,DrawY    in   10            current pixel
//  tank_X,tank_Y  out  10            tank top-left
//  tank_dir       out  2             dir_t: UP/RIGHT/LEFT/DOWN
//  bullet_active  out  NUM_BULLETS   slot i in flight
//  bullet_X,bullet_Y out 10*NUM_BULLETS  slot i top-left at [10i+9:10i]
//  fire_event     out  1             1-cycle pulse when a shot is launched
//  is_tank        out  1             pixel inside tank
//  is_bullet      out  1             pixel inside any active bullet
//  bullet_idx     out  3             lowest active slot containing pixel (0 if none)
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge Clk): tank_X/Y=X_Start/Y_Start, dir=UP, all slots free with
//   X/Y=0, cooldown=0, fire_prev=0, fire_event=0, tick pipeline cleared. Mid-flight reset
//   kills all bullets.
//  tick = registered (frame_clk & ~frame_clk_d): 1 Clk wide, 2 Clk after frame_clk rises.
//   All state below updates only on tick; else state holds. fire_event is 0 on non-tick cycles.
//  Move: scan key slots 0..NUM_KEYS-1; the first movement code wins.
//   Codes: 1A/52=UP, 16/51=DOWN, 04/50=LEFT, 07/4F=RIGHT.
//   dir updates; position steps by TANK_STEP.
//   Saturate (no bounce, no wrap) to X in [X_MIN, X_MAX-TANK_W+1], Y in [Y_MIN, Y_MAX-TANK_H+1].
//   Compute with 11-bit signed.
//   No movement code: position and dir hold.
//  Fire: fire_now = any key slot == 2C or 28.
//   Launch iff fire_now & ~fire_prev & cooldown==0 & a free slot exists; fire_prev <= fire_now every tick.
//   Held key fires once.
//   Slot = lowest-index free slot from PRE-tick state: a slot retiring this tick is not reused this tick.
//   Muzzle uses pre-move tank position and post-update dir:
//    UP    (X+TANK_W/2-BUL_W/2, Y-BUL_H)
//    DOWN  (X+TANK_W/2-BUL_W/2, Y+TANK_H)
//    LEFT  (X-BUL_W, Y+TANK_H/2-BUL_H/2)
//    RIGHT (X+TANK_W, Y+TANK_H/2-BUL_H/2)
//   If the muzzle is outside the field, no launch and cooldown is not loaded.
//   Launch: cooldown<=COOLDOWN, fire_event=1. Otherwise cooldown decrements, saturating at 0.
//   Moving and firing in the same tick is legal.
//  Bullet slot: FREE -> FLY on launch, with its dir latched.
//   Each tick in FLY, step BUL_STEP in the latched dir.
//   If the next position would put any bullet pixel outside [MIN,MAX] (signed 11-bit check),
//   FLY -> FREE instead of moving; X/Y hold their last values.
//   A newly launched bullet does not move on its launch tick.
//  Pixel outputs (combinational, half-open boxes):
//   is_tank = DrawX in [tank_X, tank_X+TANK_W) & DrawY in [tank_Y, tank_Y+TANK_H).
//   is_bullet / bullet_idx use the same rule per active slot.
// STRUCTURE
//  tank_pkg: dir_t enum, keycode localparams (KEY_W..KEY_FIRE_ENTER), muzzle offset function.
//  Sub-module bullet_slot (one per slot via generate): FREE/FLY FSM, position, latched dir,
//   retire check, pixel hit. Parent holds tick detect, move, cooldown, allocator, pixel OR/priority.
// TESTING
//  1 Reset with X_Start=100,Y_Start=200, then 3 ticks, no keys -> tank (100,200), dir UP,
//    bullet_active=0, fire_event never 1.
//  2 Key 04 for 5 ticks from X=2 -> X=1,0,0,0,0, dir LEFT. Key 07 at X=607 -> saturates at X=608.
//  3 Key 2C held 40 ticks, at (100,200) UP -> one launch at (112,192), then 192-5k per tick.
//    Release then re-press before 15 ticks -> no launch; re-press after cooldown -> slot 1 launches.
//  4 COOLDOWN=0, 2C toggled every tick, NUM_BULLETS=4 -> slots 0..3 fill; 5th press no launch.
//    Slot 0 retires, next press reuses slot 0.
//  5 UP bullet at Y=3, BUL_STEP=5 -> retires next tick with Y held at 3.
//    Retire and new press on same tick -> retiring slot not chosen.
//  6 Keys {04,2C} in same report -> tank moves left and fires LEFT.
//    Reset_n=0 mid-flight -> all slots free next cycle.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared types and helpers for the multi-bullet tank controller.
// Holds the direction enum, slot FSM states, USB keycodes and muzzle offsets.
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic {
        S_FREE = 1'b0,
        S_FLY  = 1'b1
    } slot_state_t;

    // WASD and arrow keys both steer; space or enter fires.
    localparam logic [7:0] KEY_W          = 8'h1A;
    localparam logic [7:0] KEY_S          = 8'h16;
    localparam logic [7:0] KEY_A          = 8'h04;
    localparam logic [7:0] KEY_D          = 8'h07;
    localparam logic [7:0] KEY_UP         = 8'h52;
    localparam logic [7:0] KEY_DOWN       = 8'h51;
    localparam logic [7:0] KEY_LEFT       = 8'h50;
    localparam logic [7:0] KEY_RIGHT      = 8'h4F;
    localparam logic [7:0] KEY_FIRE_SPACE = 8'h2C;
    localparam logic [7:0] KEY_FIRE_ENTER = 8'h28;

    // Offset of a new bullet's top-left from the tank's top-left.
    function automatic logic signed [10:0] muzzle_dx(
        input dir_t d,
        input int   tank_w,
        input int   bul_w
    );
        logic signed [10:0] r;
        unique case (d)
            DIR_UP, DIR_DOWN: r = 11'(tank_w / 2 - bul_w / 2);
            DIR_LEFT:         r = 11'(-bul_w);
            DIR_RIGHT:        r = 11'(tank_w);
        endcase
        return r;
    endfunction

    function automatic logic signed [10:0] muzzle_dy(
        input dir_t d,
        input int   tank_h,
        input int   bul_h
    );
        logic signed [10:0] r;
        unique case (d)
            DIR_LEFT, DIR_RIGHT: r = 11'(tank_h / 2 - bul_h / 2);
            DIR_UP:              r = 11'(-bul_h);
            DIR_DOWN:            r = 11'(tank_h);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tank_ctrl_multi_slot.sv
// One bullet slot: FREE/FLY state, position, latched direction, pixel hit.
// Ports: clk_i/rst_ni, tick_i frame step, launch_* load, draw_* pixel,
//        active_o/x_o/y_o state, hit_o pixel inside this active bullet.
module bullet_slot
    import tank_pkg::*;
#(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int BUL_W    = 8,
    parameter int BUL_H    = 8,
    parameter int BUL_STEP = 5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       launch_i,
    input  logic [9:0] launch_x_i,
    input  logic [9:0] launch_y_i,
    input  dir_t       launch_dir_i,
    input  logic [9:0] draw_x_i,
    input  logic [9:0] draw_y_i,
    output logic       active_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       hit_o
);

    // Legal range of the top-left corner so the whole sprite stays inside.
    localparam logic signed [10:0] XLO  = 11'(X_MIN);
    localparam logic signed [10:0] XHI  = 11'(X_MAX - BUL_W + 1);
    localparam logic signed [10:0] YLO  = 11'(Y_MIN);
    localparam logic signed [10:0] YHI  = 11'(Y_MAX - BUL_H + 1);
    localparam logic signed [10:0] STEP = 11'(BUL_STEP);

    slot_state_t        state_q;
    logic [9:0]         x_q;
    logic [9:0]         y_q;
    dir_t               dir_q;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic               leaves;

    always_comb begin
        dx = '0;
        dy = '0;
        unique case (dir_q)
            DIR_UP:    dy = -STEP;
            DIR_DOWN:  dy = STEP;
            DIR_LEFT:  dx = -STEP;
            DIR_RIGHT: dx = STEP;
        endcase
        nx = $signed({1'b0, x_q}) + dx;
        ny = $signed({1'b0, y_q}) + dy;
        leaves = (nx < XLO) || (nx > XHI) ||
                 (ny < YLO) || (ny > YHI);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_FREE;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= DIR_UP;
        end else if (tick_i) begin
            unique case (state_q)
                S_FREE: begin
                    if (launch_i) begin
                        state_q <= S_FLY;
                        x_q     <= launch_x_i;
                        y_q     <= launch_y_i;
                        dir_q   <= launch_dir_i;
                    end
                end
                S_FLY: begin
                    // Retire in place rather than clip at the edge.
                    if (leaves) begin
                        state_q <= S_FREE;
                    end else begin
                        x_q <= nx[9:0];
                        y_q <= ny[9:0];
                    end
                end
            endcase
        end
    end

    assign active_o = (state_q == S_FLY);
    assign x_o      = x_q;
    assign y_o      = y_q;

    assign hit_o = active_o &&
        ({1'b0, draw_x_i} >= {1'b0, x_q}) &&
        ({1'b0, draw_x_i} <  {1'b0, x_q} + 11'(BUL_W)) &&
        ({1'b0, draw_y_i} >= {1'b0, y_q}) &&
        ({1'b0, draw_y_i} <  {1'b0, y_q} + 11'(BUL_H));

endmodule

// File: rtl/tank_ctrl_multi.sv
// Per-player tank: frame tick, keyboard move, cooldown-limited fire into a bullet pool.
// Ports: Clk/Reset_n, frame_clk strobe, X/Y_Start spawn, keycodes report, DrawX/Y pixel;
//        tank_X/Y/dir, bullet_active/X/Y, fire_event, is_tank, is_bullet, bullet_idx.
module tank_ctrl_multi
    import tank_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int NUM_KEYS    = 2,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int TANK_W      = 32,
    parameter int TANK_H      = 32,
    parameter int BUL_W       = 8,
    parameter int BUL_H       = 8,
    parameter int TANK_STEP   = 1,
    parameter int BUL_STEP    = 5,
    parameter int COOLDOWN    = 15
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_clk,
    input  logic [9:0]                X_Start,
    input  logic [9:0]                Y_Start,
    input  logic [8*NUM_KEYS-1:0]     keycodes,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    output logic [9:0]                tank_X,
    output logic [9:0]                tank_Y,
    output dir_t                      tank_dir,
    output logic [NUM_BULLETS-1:0]    bullet_active,
    output logic [10*NUM_BULLETS-1:0] bullet_X,
    output logic [10*NUM_BULLETS-1:0] bullet_Y,
    output logic                      fire_event,
    output logic                      is_tank,
    output logic                      is_bullet,
    output logic [2:0]                bullet_idx
);

    localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic signed [10:0] TSTEP = 11'(TANK_STEP);
    localparam logic signed [10:0] TXLO  = 11'(X_MIN);
    localparam logic signed [10:0] TXHI  = 11'(X_MAX - TANK_W + 1);
    localparam logic signed [10:0] TYLO  = 11'(Y_MIN);
    localparam logic signed [10:0] TYHI  = 11'(Y_MAX - TANK_H + 1);
    localparam logic [9:0]         TXLO10 = 10'(X_MIN);
    localparam logic [9:0]         TXHI10 = 10'(X_MAX - TANK_W + 1);
    localparam logic [9:0]         TYLO10 = 10'(Y_MIN);
    localparam logic [9:0]         TYHI10 = 10'(Y_MAX - TANK_H + 1);
    localparam logic signed [10:0] BXLO  = 11'(X_MIN);
    localparam logic signed [10:0] BXHI  = 11'(X_MAX - BUL_W + 1);
    localparam logic signed [10:0] BYLO  = 11'(Y_MIN);
    localparam logic signed [10:0] BYHI  = 11'(Y_MAX - BUL_H + 1);

    logic               fclk_d_q;
    logic               tick_q;
    logic [9:0]         tank_x_q, tank_x_d;
    logic [9:0]         tank_y_q, tank_y_d;
    dir_t               dir_q, dir_d;
    logic               fire_prev_q;
    logic [CDW-1:0]     cd_q, cd_d;
    logic               fire_event_q;

    logic [7:0]         key;
    logic               k_up, k_dn, k_lf, k_rt;
    logic               mv_found;
    logic               fire_now;
    logic signed [10:0] sx, sy, nx, ny;
    logic signed [10:0] mz_x, mz_y;
    logic               mz_ok;
    logic               free_found;
    logic [2:0]         free_idx;
    logic               launch_go;
    logic [NUM_BULLETS-1:0] launch_vec;
    logic [NUM_BULLETS-1:0] slot_act;
    logic [NUM_BULLETS-1:0] slot_hit;
    logic               hit_found;

    // Key scan: the first movement code in slot order wins; fire from any slot.
    always_comb begin
        key      = '0;
        k_up     = 1'b0;
        k_dn     = 1'b0;
        k_lf     = 1'b0;
        k_rt     = 1'b0;
        mv_found = 1'b0;
        fire_now = 1'b0;
        dir_d    = dir_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            key  = keycodes[8*k +: 8];
            k_up = (key == KEY_W) || (key == KEY_UP);
            k_dn = (key == KEY_S) || (key == KEY_DOWN);
            k_lf = (key == KEY_A) || (key == KEY_LEFT);
            k_rt = (key == KEY_D) || (key == KEY_RIGHT);
            if (!mv_found && (k_up || k_dn || k_lf || k_rt)) begin
                mv_found = 1'b1;
                unique case (1'b1)
                    k_up:    dir_d = DIR_UP;
                    k_dn:    dir_d = DIR_DOWN;
                    k_lf:    dir_d = DIR_LEFT;
                    default: dir_d = DIR_RIGHT;
                endcase
            end
            if ((key == KEY_FIRE_SPACE) || (key == KEY_FIRE_ENTER)) begin
                fire_now = 1'b1;
            end
        end
    end

    // Tank step with saturation at the field edges.
    always_comb begin
        sx = '0;
        sy = '0;
        if (mv_found) begin
            unique case (dir_d)
                DIR_UP:    sy = -TSTEP;
                DIR_DOWN:  sy = TSTEP;
                DIR_LEFT:  sx = -TSTEP;
                DIR_RIGHT: sx = TSTEP;
            endcase
        end
        nx = $signed({1'b0, tank_x_q}) + sx;
        ny = $signed({1'b0, tank_y_q}) + sy;
        tank_x_d = tank_x_q;
        tank_y_d = tank_y_q;
        if (mv_found) begin
            tank_x_d = (nx < TXLO) ? TXLO10 :
                       (nx > TXHI) ? TXHI10 : nx[9:0];
            tank_y_d = (ny < TYLO) ? TYLO10 :
                       (ny > TYHI) ? TYHI10 : ny[9:0];
        end
    end

    // Muzzle from the pre-move position but the freshly chosen direction.
    always_comb begin
        mz_x  = $signed({1'b0, tank_x_q}) + muzzle_dx(dir_d, TANK_W, BUL_W);
        mz_y  = $signed({1'b0, tank_y_q}) + muzzle_dy(dir_d, TANK_H, BUL_H);
        mz_ok = (mz_x >= BXLO) && (mz_x <= BXHI) &&
                (mz_y >= BYLO) && (mz_y <= BYHI);
    end

    // Allocation looks at pre-tick occupancy, so a retiring slot stays busy.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!free_found && !slot_act[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
        launch_go = tick_q && fire_now && !fire_prev_q &&
                    (cd_q == '0) && free_found && mz_ok;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            launch_vec[i] = launch_go && (free_idx == 3'(i));
        end
        cd_d = cd_q;
        if (launch_go) begin
            cd_d = CDW'(COOLDOWN);
        end else if (cd_q != '0) begin
            cd_d = cd_q - CDW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fclk_d_q     <= 1'b0;
            tick_q       <= 1'b0;
            tank_x_q     <= X_Start;
            tank_y_q     <= Y_Start;
            dir_q        <= DIR_UP;
            fire_prev_q  <= 1'b0;
            cd_q         <= '0;
            fire_event_q <= 1'b0;
        end else begin
            fclk_d_q     <= frame_clk;
            tick_q       <= frame_clk & ~fclk_d_q;
            fire_event_q <= launch_go;
            if (tick_q) begin
                tank_x_q    <= tank_x_d;
                tank_y_q    <= tank_y_d;
                dir_q       <= dir_d;
                fire_prev_q <= fire_now;
                cd_q        <= cd_d;
            end
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        logic [9:0] sx_w;
        logic [9:0] sy_w;

        bullet_slot #(
            .X_MIN    (X_MIN),
            .X_MAX    (X_MAX),
            .Y_MIN    (Y_MIN),
            .Y_MAX    (Y_MAX),
            .BUL_W    (BUL_W),
            .BUL_H    (BUL_H),
            .BUL_STEP (BUL_STEP)
        ) u_slot (
            .clk_i        (Clk),
            .rst_ni       (Reset_n),
            .tick_i       (tick_q),
            .launch_i     (launch_vec[g]),
            .launch_x_i   (mz_x[9:0]),
            .launch_y_i   (mz_y[9:0]),
            .launch_dir_i (dir_d),
            .draw_x_i     (DrawX),
            .draw_y_i     (DrawY),
            .active_o     (slot_act[g]),
            .x_o          (sx_w),
            .y_o          (sy_w),
            .hit_o        (slot_hit[g])
        );

        assign bullet_X[10*g +: 10] = sx_w;
        assign bullet_Y[10*g +: 10] = sy_w;
    end

    // Lowest-index hit wins the bullet index.
    always_comb begin
        hit_found  = 1'b0;
        bullet_idx = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!hit_found && slot_hit[i]) begin
                hit_found  = 1'b1;
                bullet_idx = 3'(i);
            end
        end
        is_bullet = hit_found;
    end

    assign is_tank =
        ({1'b0, DrawX} >= {1'b0, tank_x_q}) &&
        ({1'b0, DrawX} <  {1'b0, tank_x_q} + 11'(TANK_W)) &&
        ({1'b0, DrawY} >= {1'b0, tank_y_q}) &&
        ({1'b0, DrawY} <  {1'b0, tank_y_q} + 11'(TANK_H));

    assign tank_X        = tank_x_q;
    assign tank_Y        = tank_y_q;
    assign tank_dir      = dir_q;
    assign bullet_active = slot_act;
    assign fire_event    = fire_event_q;

endmodule

// File: tb/tb_tank_ctrl_multi.sv
// Scoreboard bench for tank_ctrl_multi: default instance plus a zero-cooldown one.
// Expectations are queued per frame and compared once the frame has settled.
module tb_tank_ctrl_multi;

    localparam int K_TX  = 0;
    localparam int K_TY  = 1;
    localparam int K_DIR = 2;
    localparam int K_ACT = 3;
    localparam int K_BX  = 4;
    localparam int K_BY  = 5;
    localparam int K_FE  = 6;
    localparam int K_IST = 7;
    localparam int K_ISB = 8;
    localparam int K_IDX = 9;

    typedef struct {
        string tag;
        int    sel;
        int    kind;
        int    idx;
        int    exp;
    } sb_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  X_Start = '0;
    logic [9:0]  Y_Start = '0;
    logic [15:0] keycodes = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;

    logic [9:0]  a_tx, a_ty, b_tx, b_ty;
    logic [1:0]  a_dir, b_dir;
    logic [3:0]  a_act, b_act;
    logic [39:0] a_bx, a_by, b_bx, b_by;
    logic        a_fe, b_fe, a_ist, b_ist, a_isb, b_isb;
    logic [2:0]  a_idx, b_idx;

    int checks = 0;
    int errors = 0;
    int tot_a = 0;
    int tot_b = 0;
    int base_a, base_b, fe_a, fe_b;
    sb_t sb[$];

    always #10 Clk = ~Clk;

    tank_ctrl_multi u_a (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .X_Start(X_Start), .Y_Start(Y_Start), .keycodes(keycodes),
        .DrawX(DrawX), .DrawY(DrawY),
        .tank_X(a_tx), .tank_Y(a_ty), .tank_dir(a_dir),
        .bullet_active(a_act), .bullet_X(a_bx), .bullet_Y(a_by),
        .fire_event(a_fe), .is_tank(a_ist), .is_bullet(a_isb),
        .bullet_idx(a_idx)
    );

    tank_ctrl_multi #(.COOLDOWN(0)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .X_Start(X_Start), .Y_Start(Y_Start), .keycodes(keycodes),
        .DrawX(DrawX), .DrawY(DrawY),
        .tank_X(b_tx), .tank_Y(b_ty), .tank_dir(b_dir),
        .bullet_active(b_act), .bullet_X(b_bx), .bullet_Y(b_by),
        .fire_event(b_fe), .is_tank(b_ist), .is_bullet(b_isb),
        .bullet_idx(b_idx)
    );

    always @(negedge Clk) begin
        if (a_fe) tot_a++;
        if (b_fe) tot_b++;
    end

    function automatic int obs(input int sel, input int kind, input int idx);
        case (kind)
            K_TX:  return (sel == 0) ? int'(a_tx) : int'(b_tx);
            K_TY:  return (sel == 0) ? int'(a_ty) : int'(b_ty);
            K_DIR: return (sel == 0) ? int'(a_dir) : int'(b_dir);
            K_ACT: return (sel == 0) ? int'(a_act) : int'(b_act);
            K_BX:  return (sel == 0) ? int'(a_bx[10*idx +: 10])
                                     : int'(b_bx[10*idx +: 10]);
            K_BY:  return (sel == 0) ? int'(a_by[10*idx +: 10])
                                     : int'(b_by[10*idx +: 10]);
            K_FE:  return (sel == 0) ? fe_a : fe_b;
            K_IST: return (sel == 0) ? int'(a_ist) : int'(b_ist);
            K_ISB: return (sel == 0) ? int'(a_isb) : int'(b_isb);
            K_IDX: return (sel == 0) ? int'(a_idx) : int'(b_idx);
            default: return -1;
        endcase
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input int sel, input int kind, input int idx,
                           input int exp, input string tag);
        sb_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, obs(e.sel, e.kind, e.idx), e.exp);
        end
    endtask

    task automatic do_reset(input int x, input int y);
        @(negedge Clk);
        Reset_n   = 1'b0;
        keycodes  = '0;
        frame_clk = 1'b0;
        X_Start   = 10'(x);
        Y_Start   = 10'(y);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // One frame strobe; all frame updates and the fire pulse settle inside.
    task automatic tick();
        base_a = tot_a;
        base_b = tot_b;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        fe_a = tot_a - base_a;
        fe_b = tot_b - base_b;
    endtask

    task automatic pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
    endtask

    initial begin
        fe_a = 0;
        fe_b = 0;

        // Reset state and idle frames.
        do_reset(100, 200);
        sb_push(0, K_TX, 0, 100, "rst_tx");
        sb_push(0, K_TY, 0, 200, "rst_ty");
        sb_push(0, K_DIR, 0, 0, "rst_dir");
        sb_push(0, K_ACT, 0, 0, "rst_act");
        sb_push(1, K_ACT, 0, 0, "rst_act_b");
        drain();
        for (int k = 0; k < 3; k++) begin
            tick();
            sb_push(0, K_TX, 0, 100, "idle_tx");
            sb_push(0, K_TY, 0, 200, "idle_ty");
            sb_push(0, K_DIR, 0, 0, "idle_dir");
            sb_push(0, K_ACT, 0, 0, "idle_act");
            sb_push(0, K_FE, 0, 0, "idle_fe");
            drain();
        end
        pix(100, 200); sb_push(0, K_IST, 0, 1, "tank_tl"); drain();
        pix(131, 231); sb_push(0, K_IST, 0, 1, "tank_br"); drain();
        pix(132, 200); sb_push(0, K_IST, 0, 0, "tank_xo"); drain();
        pix(100, 232); sb_push(0, K_IST, 0, 0, "tank_yo"); drain();

        // Left saturation at X_MIN, right saturation at 608.
        do_reset(2, 200);
        keycodes = 16'h0004;
        for (int k = 1; k <= 5; k++) begin
            tick();
            sb_push(0, K_TX, 0, (k == 1) ? 1 : 0, $sformatf("left_%0d", k));
            sb_push(0, K_DIR, 0, 2, "left_dir");
            drain();
        end
        do_reset(607, 200);
        keycodes = 16'h0007;
        for (int k = 0; k < 2; k++) begin
            tick();
            sb_push(0, K_TX, 0, 608, "right_sat");
            sb_push(0, K_DIR, 0, 1, "right_dir");
            sb_push(0, K_TY, 0, 200, "right_ty");
            drain();
        end

        // Arrow-up in slot 1 saturates at top; slot 0 wins over slot 1.
        do_reset(300, 1);
        keycodes = 16'h5200;
        for (int k = 0; k < 2; k++) begin
            tick();
            sb_push(0, K_TY, 0, 0, "up_sat");
            sb_push(0, K_DIR, 0, 0, "up_dir");
            drain();
        end
        keycodes = 16'h0716;
        tick();
        sb_push(0, K_TY, 0, 1, "slot0_wins_y");
        sb_push(0, K_TX, 0, 300, "slot0_wins_x");
        sb_push(0, K_DIR, 0, 3, "slot0_wins_dir");
        drain();

        // Held fire key: one launch, bullet climbs until it retires.
        do_reset(100, 200);
        keycodes = 16'h002C;
        for (int k = 1; k <= 40; k++) begin
            tick();
            sb_push(0, K_FE, 0, (k == 1) ? 1 : 0, $sformatf("hold_fe_%0d", k));
            sb_push(0, K_BX, 0, 112, "hold_bx");
            if (k <= 39) begin
                sb_push(0, K_ACT, 0, 1, $sformatf("hold_act_%0d", k));
                sb_push(0, K_BY, 0, 192 - 5 * (k - 1), $sformatf("hold_by_%0d", k));
            end else begin
                sb_push(0, K_ACT, 0, 0, "hold_retired");
                sb_push(0, K_BY, 0, 2, "hold_by_held");
            end
            drain();
        end

        // Cooldown: early re-press ignored, press after cooldown uses slot 1.
        do_reset(100, 200);
        for (int k = 1; k <= 17; k++) begin
            keycodes = (k == 1 || k == 3 || k == 17) ? 16'h002C : 16'h0000;
            tick();
            if (k == 1) begin
                sb_push(0, K_FE, 0, 1, "cd_first");
                sb_push(0, K_ACT, 0, 1, "cd_first_act");
            end
            if (k == 3) begin
                sb_push(0, K_FE, 0, 0, "cd_blocked");
                sb_push(0, K_ACT, 0, 1, "cd_blocked_act");
            end
            if (k == 17) begin
                sb_push(0, K_FE, 0, 1, "cd_refire");
                sb_push(0, K_ACT, 0, 3, "cd_refire_act");
                sb_push(0, K_BX, 1, 112, "cd_bx1");
                sb_push(0, K_BY, 1, 192, "cd_by1");
                sb_push(0, K_BY, 0, 112, "cd_by0");
            end
            drain();
        end
        pix(112, 192); sb_push(0, K_ISB, 0, 1, "pix_b1");
        sb_push(0, K_IDX, 0, 1, "pix_b1_idx"); drain();
        pix(119, 199); sb_push(0, K_ISB, 0, 1, "pix_b1_br");
        sb_push(0, K_IDX, 0, 1, "pix_b1_br_idx"); drain();
        pix(120, 192); sb_push(0, K_ISB, 0, 0, "pix_b1_xo");
        sb_push(0, K_IDX, 0, 0, "pix_none_idx"); drain();
        pix(115, 119); sb_push(0, K_ISB, 0, 1, "pix_b0");
        sb_push(0, K_IDX, 0, 0, "pix_b0_idx"); drain();

        // Zero cooldown: fill pool, full pool refuses, freed slot 0 reused.
        do_reset(100, 200);
        for (int k = 1; k <= 41; k++) begin
            keycodes = (k % 2 == 1) ? 16'h002C : 16'h0000;
            tick();
            if (k == 3) sb_push(1, K_ACT, 0, 3, "pool_act3");
            if (k == 7) begin
                sb_push(1, K_FE, 0, 1, "pool_fe7");
                sb_push(1, K_ACT, 0, 15, "pool_full");
            end
            if (k == 9) begin
                sb_push(1, K_FE, 0, 0, "pool_refuse");
                sb_push(1, K_ACT, 0, 15, "pool_refuse_act");
            end
            if (k == 40) begin
                sb_push(1, K_FE, 0, 0, "pool_fe40");
                sb_push(1, K_ACT, 0, 14, "pool_s0_retired");
                sb_push(1, K_BY, 0, 2, "pool_s0_held");
            end
            if (k == 41) begin
                sb_push(1, K_FE, 0, 1, "pool_reuse_fe");
                sb_push(1, K_ACT, 0, 15, "pool_reuse_act");
                sb_push(1, K_BY, 0, 192, "pool_reuse_by");
                sb_push(1, K_BX, 0, 112, "pool_reuse_bx");
            end
            drain();
        end

        // Retire at Y=3 and a same-tick press that must pick slot 1.
        do_reset(100, 16);
        keycodes = 16'h002C;
        tick();
        sb_push(1, K_FE, 0, 1, "edge_fe1");
        sb_push(1, K_BY, 0, 8, "edge_by0");
        drain();
        keycodes = 16'h0000;
        tick();
        sb_push(1, K_BY, 0, 3, "edge_by3");
        sb_push(1, K_ACT, 0, 1, "edge_act");
        drain();
        keycodes = 16'h002C;
        tick();
        sb_push(1, K_FE, 0, 1, "edge_fe3");
        sb_push(1, K_ACT, 0, 2, "edge_slot1");
        sb_push(1, K_BY, 0, 3, "edge_by_held");
        sb_push(1, K_BY, 1, 8, "edge_by1");
        drain();

        // Muzzle off-field: no launch and no cooldown load.
        do_reset(100, 4);
        keycodes = 16'h002C;
        tick();
        sb_push(0, K_FE, 0, 0, "mz_out_fe");
        sb_push(0, K_ACT, 0, 0, "mz_out_act");
        drain();
        keycodes = 16'h0000;
        tick();
        keycodes = 16'h2C16;
        tick();
        sb_push(0, K_FE, 0, 1, "mz_down_fe");
        sb_push(0, K_BY, 0, 36, "mz_down_by");
        sb_push(0, K_TY, 0, 5, "mz_down_ty");
        drain();

        // Move and fire together, then reset mid-flight.
        do_reset(100, 200);
        keycodes = 16'h2C04;
        tick();
        sb_push(0, K_TX, 0, 99, "mf_tx");
        sb_push(0, K_DIR, 0, 2, "mf_dir");
        sb_push(0, K_FE, 0, 1, "mf_fe");
        sb_push(0, K_BX, 0, 92, "mf_bx");
        sb_push(0, K_BY, 0, 212, "mf_by");
        drain();
        tick();
        sb_push(0, K_TX, 0, 98, "mf_tx2");
        sb_push(0, K_BX, 0, 87, "mf_bx2");
        sb_push(0, K_FE, 0, 0, "mf_fe2");
        sb_push(1, K_ACT, 0, 1, "mf_b_act");
        drain();
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        sb_push(0, K_ACT, 0, 0, "midrst_a");
        sb_push(1, K_ACT, 0, 0, "midrst_b");
        sb_push(0, K_TX, 0, 100, "midrst_tx");
        drain();
        Reset_n  = 1'b1;
        keycodes = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
